// File: rtl/uart_tx_if.sv
// CPU-side write port of the UART transmitter: byte strobe in, FIFO/line status out.
interface uart_tx_if;
    logic [7:0] send_data;
    logic       send_ce;
    logic       send_using;
    logic       send_overflow;
    logic       tx_busy;

    modport master (
        output send_data,
        output send_ce,
        input  send_using,
        input  send_overflow,
        input  tx_busy
    );

    modport slave (
        input  send_data,
        input  send_ce,
        output send_using,
        output send_overflow,
        output tx_busy
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of a start/data/stop frame FSM.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus,
    output logic      Tx
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [AW:0]   FullCount = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] BitLast   = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e        state_q;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW:0]   count_q;
    logic          overflow_q;
    logic [7:0]    shift_q;
    logic [2:0]    idx_q;
    logic [CW-1:0] baud_q;

    logic fifo_empty;
    logic bit_end;
    logic push;
    logic pop;

    assign fifo_empty = (count_q == '0);
    assign bit_end    = (baud_q == '0);
    assign bus.send_using    = (count_q == FullCount);
    assign bus.send_overflow = overflow_q;
    assign bus.tx_busy       = (state_q != StIdle) || !fifo_empty;

    // Full is judged on the registered count, so a write coinciding with a pop from full is lost.
    assign push = bus.send_ce && !bus.send_using;
    assign pop  = !fifo_empty && ((state_q == StIdle) || ((state_q == StStop) && bit_end));

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (bus.send_ce && bus.send_using) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= bus.send_data;
    end

    // Tx is registered alongside the state so the line level always matches the current bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            Tx      <= 1'b1;
            shift_q <= '0;
            idx_q   <= '0;
            baud_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        shift_q <= fifo_mem[rd_ptr_q];
                        baud_q  <= BitLast;
                        Tx      <= 1'b0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        idx_q   <= '0;
                        baud_q  <= BitLast;
                        Tx      <= shift_q[0];
                        state_q <= StData;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        baud_q  <= BitLast;
                        if (idx_q == 3'd7) begin
                            Tx      <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                            Tx    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        if (pop) begin
                            shift_q <= fifo_mem[rd_ptr_q];
                            baud_q  <= BitLast;
                            Tx      <= 1'b0;
                            state_q <= StStart;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    Tx      <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-cycle frame-level reference model, line decoder and directed sequences.
module tb_uart_tx;
    localparam int unsigned Cpb    = 4;
    localparam int unsigned Depth  = 4;
    localparam int unsigned CpbDef = 868;

    logic clk = 1'b0;
    logic rst;
    logic tx4;
    logic tx868;

    always #5 clk = ~clk;

    uart_tx_if b4 ();
    uart_tx_if b868 ();

    uart_tx #(.CLKS_PER_BIT(Cpb), .FIFO_DEPTH(Depth)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4.slave),
        .Tx  (tx4)
    );

    uart_tx dut868 (
        .clk (clk),
        .rst (rst),
        .bus (b868.slave),
        .Tx  (tx868)
    );

    typedef struct {
        logic [7:0] data;
        logic [9:0] bits;  // line levels, first-sent in the MSB
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    // Reference model: queue of bytes plus the frame in flight, tracked by cycle-in-frame.
    logic [7:0] m_q [$];
    bit         m_active;
    int         m_cyc;
    logic [7:0] m_byte;
    bit         m_ovf;

    // Independent line decoder on the small-baud DUT.
    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];
    bit         rx_act;
    int         rx_cnt;
    logic [7:0] rx_sh;

    function automatic logic frame_bit(input logic [7:0] b, input int n);
        if (n == 0) return 1'b0;
        if (n >= 9) return 1'b1;
        return b[n-1];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc_n, act, exp);
        end
    endtask

    task automatic tick(input logic ce, input logic [7:0] d, input logic r);
        int         old;
        bit         pop;
        logic [3:0] e;
        b4.send_ce   = ce;
        b4.send_data = d;
        rst          = r;
        @(posedge clk);
        cyc_n++;
        if (r) begin
            m_q.delete();
            m_active = 0;
            m_cyc    = 0;
            m_ovf    = 0;
        end else begin
            old = m_q.size();
            pop = 0;
            if (!m_active) begin
                pop = (old != 0);
            end else if (m_cyc == 10 * Cpb - 1) begin
                pop = (old != 0);
                if (!pop) m_active = 0;
            end else begin
                m_cyc++;
            end
            if (pop) begin
                m_byte   = m_q.pop_front();
                m_active = 1;
                m_cyc    = 0;
            end
            if (ce) begin
                if (old < Depth) m_q.push_back(d);
                else m_ovf = 1;
            end
        end
        #1;
        e = {m_active ? frame_bit(m_byte, m_cyc / Cpb) : 1'b1,
             m_active || (m_q.size() != 0), m_q.size() == Depth, m_ovf};
        check("per_cycle{tx,busy,using,ovf}",
              {28'd0, tx4, b4.tx_busy, b4.send_using, b4.send_overflow}, {28'd0, e});
        if (r) begin
            rx_act = 0;
        end else if (!rx_act) begin
            if (tx4 == 1'b0) begin
                rx_act = 1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt > Cpb && rx_cnt < 9 * Cpb && (rx_cnt % Cpb) == Cpb / 2)
                rx_sh = {tx4, rx_sh[7:1]};
            if (rx_cnt == 9 * Cpb + Cpb / 2) begin
                check("stop_bit", {31'd0, tx4}, 32'd1);
                rx_q.push_back(rx_sh);
                rx_act = 0;
            end
        end
    endtask

    task automatic drain(input int budget, output int fall);
        int i;
        i = 0;
        while (b4.tx_busy && i < budget) begin
            tick(1'b0, 8'h00, 1'b0);
            i++;
        end
        check("drain_done", {31'd0, b4.tx_busy}, 32'd0);
        fall = cyc_n;
    endtask

    task automatic check_rx(input string name);
        check({name, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            check(name, {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t       vecs [5];
        logic [7:0] burst [4];
        logic [9:0] pat868;
        int         bad;
        int         k;
        int         f;
        int         bad_bits [10];

        vecs[0] = '{data: 8'hA5, bits: 10'b0101001011};
        vecs[1] = '{data: 8'h3C, bits: 10'b0001111001};
        vecs[2] = '{data: 8'h81, bits: 10'b0100000011};
        vecs[3] = '{data: 8'h12, bits: 10'b0010010001};
        vecs[4] = '{data: 8'hFF, bits: 10'b0111111111};
        burst   = '{8'h00, 8'hFF, 8'h55, 8'h81};
        pat868  = 10'b0101100001;

        b868.send_ce   = 1'b0;
        b868.send_data = 8'h00;
        rx_act = 0;

        tick(1'b0, 8'h00, 1'b1);
        check("reset_tx", {31'd0, tx4}, 32'd1);
        check("reset_using", {31'd0, b4.send_using}, 32'd0);
        check("reset_overflow", {31'd0, b4.send_overflow}, 32'd0);
        check("reset_busy", {31'd0, b4.tx_busy}, 32'd0);

        // Single-byte frames from the vector table.
        for (int v = 0; v < 5; v++) begin
            tick(1'b1, vecs[v].data, 1'b0);
            k = cyc_n;
            check("pre_start_tx", {31'd0, tx4}, 32'd1);
            check("busy_rise", {31'd0, b4.tx_busy}, 32'd1);
            bad = 0;
            for (int i = 0; i < 10 * Cpb; i++) begin
                tick(1'b0, 8'h00, 1'b0);
                if (tx4 !== vecs[v].bits[9 - i / Cpb]) bad++;
            end
            check("frame_bits", bad, 0);
            drain(20, f);
            check("busy_fall_cycle", f - k, 41);
            exp_q.push_back(vecs[v].data);
            check_rx("single_rx");
        end

        // Burst of four back-to-back frames.
        k = cyc_n + 1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, burst[i], 1'b0);
            check("burst_using", {31'd0, b4.send_using}, 32'd0);
        end
        drain(400, f);
        check("burst_length", f - k, 161);
        check("burst_no_overflow", {31'd0, b4.send_overflow}, 32'd0);
        for (int i = 0; i < 4; i++) exp_q.push_back(burst[i]);
        check_rx("burst_rx");

        // Six writes into a depth-4 FIFO: fifth fills it, sixth is rejected.
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 8'(8'h10 + i), 1'b0);
            if (i == 4) begin
                check("ovf_using", {31'd0, b4.send_using}, 32'd1);
                check("ovf_not_yet", {31'd0, b4.send_overflow}, 32'd0);
            end
        end
        check("ovf_flag", {31'd0, b4.send_overflow}, 32'd1);
        drain(600, f);
        check("ovf_sticky", {31'd0, b4.send_overflow}, 32'd1);
        for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h10 + i));
        check_rx("ovf_rx");
        tick(1'b0, 8'h00, 1'b1);
        check("ovf_cleared", {31'd0, b4.send_overflow}, 32'd0);

        // Write lands on the same edge as the STOP->START pop from full.
        k = cyc_n + 1;
        for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'h20 + i), 1'b0);
        while (cyc_n < k + 40) tick(1'b0, 8'h00, 1'b0);
        check("fullpop_pre_using", {31'd0, b4.send_using}, 32'd1);
        tick(1'b1, 8'hEE, 1'b0);
        check("fullpop_overflow", {31'd0, b4.send_overflow}, 32'd1);
        check("fullpop_using", {31'd0, b4.send_using}, 32'd0);
        drain(800, f);
        for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h20 + i));
        check_rx("fullpop_rx");
        tick(1'b0, 8'h00, 1'b1);

        // Reset during data bit 3 of 0x3C with two bytes queued.
        k = cyc_n + 1;
        tick(1'b1, 8'h3C, 1'b0);
        tick(1'b1, 8'h11, 1'b0);
        tick(1'b1, 8'h22, 1'b0);
        while (cyc_n < k + 17) tick(1'b0, 8'h00, 1'b0);
        check("mid_bit3_level", {31'd0, tx4}, 32'd1);
        tick(1'b0, 8'h00, 1'b1);
        check("mid_reset_tx", {31'd0, tx4}, 32'd1);
        check("mid_reset_busy", {31'd0, b4.tx_busy}, 32'd0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 8'h00, 1'b0);
            if (tx4 !== 1'b1) bad++;
        end
        check("mid_reset_quiet", bad, 0);
        check_rx("mid_reset_none");
        tick(1'b1, 8'h12, 1'b0);
        drain(100, f);
        exp_q.push_back(8'h12);
        check_rx("post_reset_rx");

        // Random traffic against the model, with occasional resets.
        for (int i = 0; i < 1500; i++)
            tick($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 499) == 0);
        drain(1000, f);
        rx_q.delete();

        // Default baud: single 0x0D frame on the 868-cycle instance.
        tick(1'b0, 8'h00, 1'b1);
        b868.send_ce   = 1'b1;
        b868.send_data = 8'h0D;
        tick(1'b0, 8'h00, 1'b0);
        b868.send_ce = 1'b0;
        check("def_pre_start_tx", {31'd0, tx868}, 32'd1);
        check("def_busy_rise", {31'd0, b868.tx_busy}, 32'd1);
        for (int b = 0; b < 10; b++) bad_bits[b] = 0;
        for (int i = 0; i < 10 * CpbDef; i++) begin
            tick(1'b0, 8'h00, 1'b0);
            if (tx868 !== pat868[9 - i / CpbDef]) bad_bits[i / CpbDef]++;
        end
        for (int b = 0; b < 10; b++) check("def_bit_window", bad_bits[b], 0);
        check("def_busy_last", {31'd0, b868.tx_busy}, 32'd1);
        tick(1'b0, 8'h00, 1'b0);
        check("def_idle_tx", {31'd0, tx868}, 32'd1);
        check("def_busy_fall", {31'd0, b868.tx_busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
